// File: rtl/wb_write_arbiter_if.sv
// Bundle of the write-arbiter signals: ALU result, load issue/return, hazard query and register-file write port.
interface wb_write_arbiter_if #(
  parameter int LQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic             alu_valid;
  logic [4:0]       alu_addr;
  logic [31:0]      alu_data;
  logic             alu_ready;
  logic             ld_issue;
  logic [4:0]       ld_issue_addr;
  logic             ld_valid;
  logic [4:0]       ld_addr;
  logic [31:0]      ld_data;
  logic             ld_ready;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic             rs_busy;
  logic             rt_busy;
  logic             reg_write_out;
  logic [4:0]       write_addr;
  logic [31:0]      write_data;
  logic [CNT_W-1:0] lq_count;

  // Pipeline side: drives results, loads and hazard queries
  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_issue, ld_issue_addr,
    output ld_valid, ld_addr, ld_data,
    output rs_addr, rt_addr,
    input  alu_ready, ld_ready, rs_busy, rt_busy,
    input  reg_write_out, write_addr, write_data, lq_count
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_issue, ld_issue_addr,
    input  ld_valid, ld_addr, ld_data,
    input  rs_addr, rt_addr,
    output alu_ready, ld_ready, rs_busy, rt_busy,
    output reg_write_out, write_addr, write_data, lq_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges ALU results and buffered load returns onto the single register-file write port,
// with starvation-bounded ALU priority and a pending-destination scoreboard for load-use hazards.
module wb_write_arbiter #(
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  wb_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(LQ_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

  logic [4:0]       r_lq_addr [LQ_DEPTH];
  logic [31:0]      r_lq_data [LQ_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pending;
  logic [ST_W-1:0]  r_starve;
  logic             r_reg_write;
  logic [4:0]       r_write_addr;
  logic [31:0]      r_write_data;

  logic             w_empty;
  logic             w_full;
  logic             w_force;
  logic             w_push;
  logic             w_pop;
  logic             w_alu_win;
  logic             w_sel_valid;
  logic [4:0]       w_sel_addr;
  logic [31:0]      w_sel_data;
  logic [31:0]      w_set_mask;
  logic [31:0]      w_clr_mask;
  logic [31:0]      w_pending_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [ST_W-1:0]  w_starve_nxt;

  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_full  = (r_count == FULL_CNT);
  assign w_force = (r_starve == STARVE_LIM) && !w_empty;
  // A full queue refuses the return even if a pop frees a slot this cycle
  assign w_push  = bus.ld_valid && !w_full;

  assign bus.alu_ready     = !w_force;
  assign bus.ld_ready      = !w_full;
  assign bus.rs_busy       = r_pending[bus.rs_addr];
  assign bus.rt_busy       = r_pending[bus.rt_addr];
  assign bus.reg_write_out = r_reg_write;
  assign bus.write_addr    = r_write_addr;
  assign bus.write_data    = r_write_data;
  assign bus.lq_count      = r_count;

  // Write-port source selection: forced load, then ALU, then any queued load
  always_comb begin
    w_pop       = 1'b0;
    w_alu_win   = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_addr  = 5'd0;
    w_sel_data  = 32'd0;
    if (w_force) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel_addr  = r_lq_addr[r_head];
      w_sel_data  = r_lq_data[r_head];
    end else if (bus.alu_valid) begin
      w_alu_win   = 1'b1;
      w_sel_valid = 1'b1;
      w_sel_addr  = bus.alu_addr;
      w_sel_data  = bus.alu_data;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel_addr  = r_lq_addr[r_head];
      w_sel_data  = r_lq_data[r_head];
    end else begin
      w_sel_valid = 1'b0;
    end
  end

  // Next-state for scoreboard, occupancy and starvation counter
  always_comb begin
    w_set_mask = 32'd0;
    w_clr_mask = 32'd0;
    if (w_pop && (w_sel_addr != 5'd0)) begin
      w_clr_mask = 32'd1 << w_sel_addr;
    end else begin
      w_clr_mask = 32'd0;
    end
    if (bus.ld_issue && (bus.ld_issue_addr != 5'd0)) begin
      w_set_mask = 32'd1 << bus.ld_issue_addr;
    end else begin
      w_set_mask = 32'd0;
    end
    // Set is applied after clear so a same-cycle reissue keeps the register pending
    w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{(CNT_W-1){1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase

    if (w_empty || w_pop) begin
      w_starve_nxt = {ST_W{1'b0}};
    end else if (w_alu_win && (r_starve != STARVE_LIM)) begin
      w_starve_nxt = r_starve + {{(ST_W-1){1'b0}}, 1'b1};
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // State and registered write-port update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        r_lq_addr[i] <= 5'd0;
        r_lq_data[i] <= 32'd0;
      end
      r_head       <= {PTR_W{1'b0}};
      r_tail       <= {PTR_W{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_pending    <= 32'd0;
      r_starve     <= {ST_W{1'b0}};
      r_reg_write  <= 1'b0;
      r_write_addr <= 5'd0;
      r_write_data <= 32'd0;
    end else begin
      if (w_push) begin
        r_lq_addr[r_tail] <= bus.ld_addr;
        r_lq_data[r_tail] <= bus.ld_data;
        r_tail            <= r_tail + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_head <= r_head + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
      r_starve  <= w_starve_nxt;
      // Register 0 is hardwired: the source is consumed but no write is issued
      r_reg_write <= w_sel_valid && (w_sel_addr != 5'd0);
      if (w_sel_valid) begin
        r_write_addr <= w_sel_addr;
        r_write_data <= w_sel_data;
      end
    end
  end
endmodule
